// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller sitting between a CPU port and dm_mem.
// Request/response structs are shared with dm_mem and the CPU through dm_cache_pkg.
package dm_cache_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;
endpackage

module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  cpu_req_type    cpu_req,
  output cpu_result_type cpu_res,
  output mem_req_type    mem_req,
  input  mem_data_type   mem_data
);
  localparam int unsigned INDEX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = 28 - INDEX_W;

  typedef enum logic [1:0] {StIdle, StCompare, StWriteBack, StAllocate} state_e;

  state_e         state_q, state_d;
  cpu_req_type    req_q;
  cpu_result_type cpu_res_q, cpu_res_d;
  mem_req_type    mem_req_q, mem_req_d;

  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [127:0]         data_mem [NUM_LINES];

  logic [TAG_W-1:0]   req_tag, old_tag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         word;
  logic [127:0]       line, line_merged, data_wdata;
  logic [31:0]        rd_word;
  logic               hit, victim_dirty, accept;
  logic               data_we, tag_we, valid_set, dirty_set, dirty_clr;
  mem_req_type        refill_req;
  logic               unused_addr_bits;

  assign req_tag          = req_q.addr[31:4+INDEX_W];
  assign idx              = req_q.addr[4+INDEX_W-1:4];
  assign word             = req_q.addr[3:2];
  assign unused_addr_bits = ^req_q.addr[1:0];

  assign line         = data_mem[idx];
  assign old_tag      = tag_mem[idx];
  assign hit          = valid_q[idx] && (old_tag == req_tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign rd_word      = line[{word, 5'b0} +: 32];
  // Holding off while ready is high keeps a request held across its own pulse from re-issuing.
  assign accept       = (state_q == StIdle) && cpu_req.valid && !cpu_res_q.ready;

  always_comb begin
    line_merged = line;
    line_merged[{word, 5'b0} +: 32] = req_q.data;
  end

  assign refill_req = '{addr: {req_tag, idx, 4'h0}, data: mem_req_q.data, rw: 1'b0, valid: 1'b1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      req_q     <= '0;
      cpu_res_q <= '0;
      mem_req_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
    end else begin
      state_q   <= state_d;
      cpu_res_q <= cpu_res_d;
      mem_req_q <= mem_req_d;
      if (accept) req_q <= cpu_req;
      if (valid_set) valid_q[idx] <= 1'b1;
      if (dirty_set) dirty_q[idx] <= 1'b1;
      else if (dirty_clr) dirty_q[idx] <= 1'b0;
    end
  end

  // Tag/data arrays are never cleared; writes are only suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (data_we) data_mem[idx] <= data_wdata;
      if (tag_we) tag_mem[idx] <= req_tag;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (accept) state_d = StCompare;
      StCompare: begin
        if (hit) state_d = StIdle;
        else if (victim_dirty) state_d = StWriteBack;
        else state_d = StAllocate;
      end
      StWriteBack: if (mem_data.ready) state_d = StAllocate;
      StAllocate:  if (mem_data.ready) state_d = StCompare;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_res_d  = '{data: cpu_res_q.data, ready: 1'b0};
    mem_req_d  = mem_req_q;
    data_we    = 1'b0;
    data_wdata = line_merged;
    tag_we     = 1'b0;
    valid_set  = 1'b0;
    dirty_set  = 1'b0;
    dirty_clr  = 1'b0;
    case (state_q)
      StCompare: begin
        if (hit) begin
          cpu_res_d.ready = 1'b1;
          if (req_q.rw) begin
            data_we   = 1'b1;
            dirty_set = 1'b1;
          end else begin
            cpu_res_d.data = rd_word;
          end
        end else if (victim_dirty) begin
          mem_req_d = '{addr: {old_tag, idx, 4'h0}, data: line, rw: 1'b1, valid: 1'b1};
        end else begin
          mem_req_d = refill_req;
        end
      end
      StWriteBack: begin
        if (mem_data.ready) begin
          dirty_clr = 1'b1;
          mem_req_d = refill_req;
        end
      end
      StAllocate: begin
        if (mem_data.ready) begin
          data_we         = 1'b1;
          data_wdata      = mem_data.data;
          tag_we          = 1'b1;
          valid_set       = 1'b1;
          dirty_clr       = 1'b1;
          mem_req_d.valid = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign cpu_res = cpu_res_q;
  assign mem_req = mem_req_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: table of CPU requests with expected latency/data/memory traffic,
// plus hand-written sequences for reset during write-back and a request held across its ready pulse.
module tb_dm_cache_ctrl;
  import dm_cache_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  cpu_req_type    cpu_req;
  cpu_result_type cpu_res;
  mem_req_type    mem_req;
  mem_data_type   mem_data;

  dm_cache_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_res  (cpu_res),
    .mem_req  (mem_req),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Memory contents before any write: a fixed pattern derived from the line address.
  function automatic logic [127:0] lp(input logic [31:0] la);
    return {la ^ 32'h3333_0003, la ^ 32'h2222_0002, la ^ 32'h1111_0001, la};
  endfunction

  function automatic logic [31:0] wd(input logic [127:0] l, input int w);
    return l[32*w +: 32];
  endfunction

  // dm_mem model: one-cycle response, ready pulses for one cycle per operation.
  logic [127:0] store   [4096];
  bit           written [4096];
  logic         mem_ready;
  logic [127:0] mem_rdata;
  int           rd_cnt, wr_cnt;
  logic [31:0]  last_rd_addr, last_wr_addr;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
    end else if (mem_req.valid && !mem_ready) begin
      mem_ready <= 1'b1;
      if (mem_req.rw) begin
        store[mem_req.addr[15:4]]   <= mem_req.data;
        written[mem_req.addr[15:4]] <= 1'b1;
        wr_cnt                      <= wr_cnt + 1;
        last_wr_addr                <= mem_req.addr;
      end else begin
        mem_rdata    <= written[mem_req.addr[15:4]] ? store[mem_req.addr[15:4]] : lp(mem_req.addr);
        rd_cnt       <= rd_cnt + 1;
        last_rd_addr <= mem_req.addr;
      end
    end else begin
      mem_ready <= 1'b0;
    end
  end

  assign mem_data = '{data: mem_rdata, ready: mem_ready};

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] data, input logic rw,
                        output int lat, output logic [31:0] rdata, output bit saw);
    @(negedge clk);
    cpu_req = '{addr: addr, data: data, rw: rw, valid: 1'b1};
    lat = -1;
    rdata = '0;
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (mem_req.valid) saw = 1'b1;
      if (cpu_res.ready) begin
        lat = k;
        rdata = cpu_res.data;
        break;
      end
    end
    @(negedge clk);
    cpu_req.valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    int          lat;
    logic [31:0] rdata;
    int          rd_d;
    int          wr_d;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat, rd0, wr0;
    logic [31:0] rdata;
    bit          saw;
    logic [5:0]  pat;
    logic [127:0] exp_line;

    vecs[0] = '{32'h0000_1004, 32'h0, 1'b0, 4, wd(lp(32'h1000), 1), 1, 0, 32'h1000, 32'h0};
    vecs[1] = '{32'h0000_1008, 32'hDEAD_BEEF, 1'b1, 1, 32'h0, 0, 0, 32'h0, 32'h0};
    vecs[2] = '{32'h0000_5008, 32'h0, 1'b0, 6, wd(lp(32'h5000), 2), 1, 1, 32'h5000, 32'h1000};
    vecs[3] = '{32'h0000_1008, 32'h0, 1'b0, 4, 32'hDEAD_BEEF, 1, 0, 32'h1000, 32'h0};
    vecs[4] = '{32'h0000_2010, 32'h1234_5678, 1'b1, 4, 32'h0, 1, 0, 32'h2010, 32'h0};
    vecs[5] = '{32'h0000_2010, 32'h0, 1'b0, 1, 32'h1234_5678, 0, 0, 32'h0, 32'h0};
    vecs[6] = '{32'h0000_201C, 32'h0, 1'b0, 1, wd(lp(32'h2010), 3), 0, 0, 32'h0, 32'h0};
    vecs[7] = '{32'h0000_5004, 32'hCAFE_F00D, 1'b1, 4, 32'h0, 1, 0, 32'h5000, 32'h0};

    rd_cnt = 0;
    wr_cnt = 0;
    rst_n = 1'b0;
    cpu_req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset cpu_res.ready", 128'(cpu_res.ready), 128'd0);
    chk("reset cpu_res.data", 128'(cpu_res.data), 128'd0);
    chk("reset mem_req.valid", 128'(mem_req.valid), 128'd0);
    chk("reset mem_req.rw", 128'(mem_req.rw), 128'd0);
    chk("reset mem_req.addr", 128'(mem_req.addr), 128'd0);
    chk("reset mem_req.data", mem_req.data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      do_req(vecs[i].addr, vecs[i].data, vecs[i].rw, lat, rdata, saw);
      chk($sformatf("v%0d latency", i), 128'(lat), 128'(vecs[i].lat));
      chk($sformatf("v%0d mem reads", i), 128'(rd_cnt - rd0), 128'(vecs[i].rd_d));
      chk($sformatf("v%0d mem writes", i), 128'(wr_cnt - wr0), 128'(vecs[i].wr_d));
      chk($sformatf("v%0d mem_req seen", i), 128'(saw), 128'(vecs[i].rd_d != 0));
      if (!vecs[i].rw) chk($sformatf("v%0d read data", i), 128'(rdata), 128'(vecs[i].rdata));
      if (vecs[i].rd_d != 0)
        chk($sformatf("v%0d refill addr", i), 128'(last_rd_addr), 128'(vecs[i].rd_addr));
      if (vecs[i].wr_d != 0)
        chk($sformatf("v%0d evict addr", i), 128'(last_wr_addr), 128'(vecs[i].wr_addr));
    end

    exp_line = lp(32'h1000);
    exp_line[95:64] = 32'hDEAD_BEEF;
    chk("evicted line contents", store[12'h100], exp_line);

    // Reset while the dirty 0x5000 line is being written back for a miss on 0x9000.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    cpu_req = '{addr: 32'h0000_9000, data: 32'h0, rw: 1'b0, valid: 1'b1};
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (mem_req.valid && mem_req.rw) begin
        saw = 1'b1;
        break;
      end
    end
    chk("write-back reached", 128'(saw), 128'd1);
    chk("write-back addr", 128'(mem_req.addr), 128'h5000);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid-op reset mem_req.valid", 128'(mem_req.valid), 128'd0);
    chk("mid-op reset cpu_res.ready", 128'(cpu_res.ready), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_req.valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle after reset mem_req.valid", 128'(mem_req.valid), 128'd0);
    chk("abandoned write-back", 128'(wr_cnt - wr0), 128'd0);

    rd0 = rd_cnt;
    do_req(32'h0000_5004, 32'h0, 1'b0, lat, rdata, saw);
    chk("post-reset miss latency", 128'(lat), 128'd4);
    chk("post-reset refill count", 128'(rd_cnt - rd0), 128'd1);
    chk("post-reset read data", 128'(rdata), 128'(wd(lp(32'h5000), 1)));

    // Request held valid across its ready pulse: one pulse, then re-accepted after a gap cycle.
    rd0 = rd_cnt;
    @(negedge clk);
    cpu_req = '{addr: 32'h0000_5004, data: 32'h0, rw: 1'b0, valid: 1'b1};
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      pat = {pat[4:0], cpu_res.ready};
      if (i == 4) begin
        @(negedge clk);
        cpu_req.valid = 1'b0;
      end
    end
    chk("held request ready pattern", 128'(pat), 128'(6'b010010));
    chk("held request data", 128'(cpu_res.data), 128'(wd(lp(32'h5000), 1)));
    chk("held request no mem traffic", 128'(rd_cnt - rd0), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
